// File: rtl/retinex_auto_stretch.sv
// retinex_auto_stretch
//   Per-frame automatic contrast stretch for the Retinex luma stream.
//   Frame N's min/max are measured, turned into a Q8.8 gain by a serial
//   restoring divider, and applied to frame N+1 as
//   y_out = sat255(((y_in - offset) floored at 0) * gain >> 8).
//
// Ports
//   clk              pixel clock, rising edge
//   rst_n            asynchronous active-low reset
//   pixel_valid_in   y_in carries an active pixel
//   y_in[7:0]        Retinex luma in
//   pixel_valid_out  pixel_valid_in delayed 3 cycles
//   y_out[7:0]       stretched luma (0 when pixel_valid_out is low)
//   frame_done       one-cycle pulse when gain/offset are committed
//   gain[15:0]       committed gain, Q8.8
//   offset[7:0]      committed black level
//
// Handshake: no back-pressure. A pixel is accepted on every rising edge where
// pixel_valid_in is high; its result appears exactly 3 edges later with
// pixel_valid_out high for that single cycle.
module retinex_auto_stretch #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pixel_valid_in,
    input  logic [7:0]  y_in,
    output logic        pixel_valid_out,
    output logic [7:0]  y_out,
    output logic        frame_done,
    output logic [15:0] gain,
    output logic [7:0]  offset
);
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, DIV, COMMIT} state_t;

    state_t        state;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [7:0]    run_min, run_max, cal_min, cal_max;
    logic [7:0]    div_den, div_rem;
    logic [15:0]   div_quo;
    logic [3:0]    div_cnt;
    logic [15:0]   act_gain, g1;
    logic [7:0]    act_offset, d1;
    logic          v1, v2;
    logic [23:0]   p2;

    logic          x_last, y_last, last_pix, first_pix, load_coef;
    logic [7:0]    frame_min, frame_max;
    logic [15:0]   eff_gain;
    logic [7:0]    eff_offset;
    logic [8:0]    rem_sh;
    logic          rem_ge;
    logic [8:0]    rem_sub;

    assign x_last    = (x_cnt == XW'(H_ACTIVE - 1));
    assign y_last    = (y_cnt == YW'(V_ACTIVE - 1));
    assign last_pix  = pixel_valid_in && x_last && y_last;
    assign first_pix = pixel_valid_in && (x_cnt == '0) && (y_cnt == '0);

    // Min/max including the current pixel, so the last pixel counts.
    assign frame_min = (y_in < run_min) ? y_in : run_min;
    assign frame_max = (y_in > run_max) ? y_in : run_max;

    // New coefficients are taken only at the start of a frame and only when
    // no division is in flight; the first pixel already uses them.
    assign load_coef  = first_pix && (state == IDLE);
    assign eff_gain   = load_coef ? gain   : act_gain;
    assign eff_offset = load_coef ? offset : act_offset;

    // One restoring-division step: shift in the next dividend bit.
    assign rem_sh  = {div_rem, div_quo[15]};
    assign rem_ge  = (rem_sh >= {1'b0, div_den});
    assign rem_sub = rem_sh - {1'b0, div_den};

    // Raster counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (pixel_valid_in) begin
            if (x_last) begin
                x_cnt <= '0;
                y_cnt <= y_last ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    // Frame statistics. cal_* only latch while the divider is idle so a busy
    // division keeps a stable operand; that frame's stats are then dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_min <= 8'd255;
            run_max <= 8'd0;
            cal_min <= 8'd0;
            cal_max <= 8'd0;
        end else if (pixel_valid_in) begin
            if (last_pix) begin
                run_min <= 8'd255;
                run_max <= 8'd0;
                if (state == IDLE) begin
                    cal_min <= frame_min;
                    cal_max <= frame_max;
                end
            end else begin
                run_min <= frame_min;
                run_max <= frame_max;
            end
        end
    end

    // Divider / commit FSM. A flat frame commits straight from SETUP so its
    // pulse arrives 2 cycles after the last pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gain       <= 16'd256;
            offset     <= 8'd0;
            frame_done <= 1'b0;
            div_den    <= 8'd0;
            div_rem    <= 8'd0;
            div_quo    <= 16'd0;
            div_cnt    <= 4'd0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (last_pix) state <= SETUP;
                end
                SETUP: begin
                    if (cal_max == cal_min) begin
                        gain       <= 16'd256;
                        offset     <= 8'd0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        div_den <= cal_max - cal_min;
                        div_rem <= 8'd0;
                        div_quo <= 16'hFF00;   // 255 * 256
                        div_cnt <= 4'd0;
                        state   <= DIV;
                    end
                end
                DIV: begin
                    // Remainder stays below div_den, so 8 bits always suffice.
                    div_rem <= rem_ge ? rem_sub[7:0] : rem_sh[7:0];
                    div_quo <= {div_quo[14:0], rem_ge};
                    div_cnt <= div_cnt + 4'd1;
                    if (div_cnt == 4'd15) state <= COMMIT;
                end
                COMMIT: begin
                    gain       <= div_quo;
                    offset     <= cal_min;
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shadow coefficients and 3-stage pixel datapath. The gain travels with
    // the pixel so a coefficient swap never splits a pixel across two sets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_gain        <= 16'd256;
            act_offset      <= 8'd0;
            v1              <= 1'b0;
            d1              <= 8'd0;
            g1              <= 16'd256;
            v2              <= 1'b0;
            p2              <= 24'd0;
            pixel_valid_out <= 1'b0;
            y_out           <= 8'd0;
        end else begin
            if (load_coef) begin
                act_gain   <= gain;
                act_offset <= offset;
            end
            v1              <= pixel_valid_in;
            d1              <= (y_in > eff_offset) ? (y_in - eff_offset) : 8'd0;
            g1              <= eff_gain;
            v2              <= v1;
            p2              <= {16'd0, d1} * {8'd0, g1};
            pixel_valid_out <= v2;
            if (!v2)
                y_out <= 8'd0;
            else if (p2[23:16] != 8'd0)
                y_out <= 8'd255;
            else
                y_out <= p2[15:8];
        end
    end
endmodule

// File: tb/tb_retinex_auto_stretch.sv
// Bench for retinex_auto_stretch with a 4x4 frame.
module tb_retinex_auto_stretch;
    localparam int NPIX = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pixel_valid_in = 1'b0;
    logic [7:0]  y_in = 8'd0;
    logic        pixel_valid_out;
    logic [7:0]  y_out;
    logic        frame_done;
    logic [15:0] gain;
    logic [7:0]  offset;

    retinex_auto_stretch #(.H_ACTIVE(4), .V_ACTIVE(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pixel_valid_in  (pixel_valid_in),
        .y_in            (y_in),
        .pixel_valid_out (pixel_valid_out),
        .y_out           (y_out),
        .frame_done      (frame_done),
        .gain            (gain),
        .offset          (offset)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_q[$];
    int          cyc_q[$];
    int          fd_cyc_q[$];
    logic [15:0] fd_gain_q[$];
    logic [7:0]  fd_off_q[$];
    logic [7:0]  fbuf[NPIX];
    int          last_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference stretch, integer arithmetic.
    function automatic logic [7:0] model(input logic [7:0] v, input logic [15:0] g, input logic [7:0] o);
        int d;
        int q;
        d = int'(v) - int'(o);
        if (d < 0) d = 0;
        q = (d * int'(g)) / 256;
        if (q > 255) q = 255;
        return 8'(q);
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        if (pixel_valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                logic [7:0] e;
                int c;
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                check("y_out", y_out, e);
                check("latency", cyc - c, 3);
            end
        end else begin
            check("idle_y_out", y_out, 0);
        end
        if (frame_done === 1'b1) begin
            fd_cyc_q.push_back(cyc);
            fd_gain_q.push_back(gain);
            fd_off_q.push_back(offset);
        end
    end

    // driver tasks
    task automatic drive_pix(input logic [7:0] v, input logic [15:0] g, input logic [7:0] o);
        @(posedge clk); #1;
        pixel_valid_in = 1'b1;
        y_in = v;
        exp_q.push_back(model(v, g, o));
        cyc_q.push_back(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            pixel_valid_in = 1'b0;
            y_in = 8'd0;
        end
    endtask

    task automatic send_frame(input logic [15:0] g, input logic [7:0] o, input int gap);
        for (int i = 0; i < NPIX; i++) begin
            drive_pix(fbuf[i], g, o);
            if (i == NPIX - 1) last_cyc = cyc;
            else if (gap > 0) idle(gap);
        end
    endtask

    task automatic expect_commit(input int from_cyc, input int delay,
                                 input logic [15:0] g, input logic [7:0] o);
        if (fd_cyc_q.size() == 0) begin
            check("commit_present", 0, 1);
        end else begin
            check("frame_done_delay", fd_cyc_q.pop_front() - from_cyc, delay);
            check("gain", fd_gain_q.pop_front(), g);
            check("offset", fd_off_q.pop_front(), o);
        end
    endtask

    task automatic expect_no_commit();
        check("extra_commit", fd_cyc_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        pixel_valid_in = 1'b0;
        y_in = 8'd0;
        exp_q.delete();
        cyc_q.delete();
        @(negedge clk);
        check("rst_y_out", y_out, 0);
        check("rst_valid_out", pixel_valid_out, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_gain", gain, 256);
        check("rst_offset", offset, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int l5, l6, l9;

    initial begin
        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_y_out", y_out, 0);
        check("rst_valid_out", pixel_valid_out, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_gain", gain, 256);
        check("rst_offset", offset, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // F1: ramp 0..255, identity
        for (int i = 0; i < NPIX; i++) fbuf[i] = 8'(i * 17);
        send_frame(16'd256, 8'd0, 0);
        idle(40);
        expect_commit(last_cyc, 19, 16'd256, 8'd0);

        // F2: range 50..150, still identity
        fbuf = '{50,150,100,60,70,80,90,110,120,130,140,55,65,75,85,95};
        send_frame(16'd256, 8'd0, 0);
        idle(40);
        expect_commit(last_cyc, 19, 16'd652, 8'd50);

        // F3: stretched by 652/50 (100->127, 150->254, 40->0, 255->255)
        fbuf = '{100,150,40,255,50,60,70,80,90,110,120,130,140,200,220,45};
        send_frame(16'd652, 8'd50, 0);
        idle(40);
        expect_commit(last_cyc, 19, 16'd303, 8'd40);

        // F4: flat frame, pass-through commit after 2 cycles
        for (int i = 0; i < NPIX; i++) fbuf[i] = 8'd80;
        send_frame(16'd303, 8'd40, 0);
        idle(40);
        expect_commit(last_cyc, 2, 16'd256, 8'd0);

        // F5 (identity), 5-cycle blanking, F6 starts while dividing -> identity
        fbuf = '{50,150,100,60,70,80,90,110,120,130,140,55,65,75,85,95};
        send_frame(16'd256, 8'd0, 0);
        l5 = last_cyc;
        idle(5);
        send_frame(16'd256, 8'd0, 0);
        l6 = last_cyc;
        expect_commit(l5, 19, 16'd652, 8'd50);

        // F7 back-to-back: starts and ends while busy -> identity, stats dropped
        for (int i = 0; i < NPIX; i++) fbuf[i] = 8'(i * 17);
        send_frame(16'd256, 8'd0, 0);
        idle(30);
        expect_commit(l6, 19, 16'd652, 8'd50);
        expect_no_commit();

        // F8: gapped valid (every 3rd cycle) with F6's coefficients
        fbuf = '{60,200,100,150,70,80,90,110,120,130,140,160,170,180,190,65};
        send_frame(16'd652, 8'd50, 2);
        idle(30);
        expect_commit(last_cyc, 19, 16'd466, 8'd60);

        // F9, then reset while dividing
        fbuf = '{50,150,100,60,70,80,90,110,120,130,140,55,65,75,85,95};
        send_frame(16'd466, 8'd60, 0);
        l9 = last_cyc;
        idle(5);
        do_reset();
        idle(25);
        expect_no_commit();

        // partial line, then reset mid-line
        for (int i = 0; i < 6; i++) drive_pix(8'(i * 30), 16'd256, 8'd0);
        idle(1);
        do_reset();
        idle(3);

        // F11: first frame after reset, identity; counters restart cleanly
        fbuf = '{10,20,15,12,18,11,13,14,16,17,19,10,20,15,14,13};
        send_frame(16'd256, 8'd0, 0);
        idle(30);
        expect_commit(last_cyc, 19, 16'd6528, 8'd10);

        // F12: strong gain, saturation
        fbuf = '{15,25,10,12,30,5,200,11,13,14,16,17,18,19,20,21};
        send_frame(16'd6528, 8'd10, 0);
        idle(30);
        expect_commit(last_cyc, 19, 16'd334, 8'd5);

        idle(5);
        check("pending_outputs", exp_q.size(), 0);
        expect_no_commit();
        if (l9 < 0) $display("unreachable");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
